// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag layout, burst length and arbiter state encoding.
package sysbus_pkg;

    localparam int unsigned SYSBUS_BEATS = 8;
    localparam int unsigned BEAT_W       = 3;

    // Tag layout: {rw[12], type[11:8], id[7:0]}
    localparam int unsigned TAG_RW_BIT   = 12;
    localparam int unsigned TAG_TYPE_LSB = 8;
    localparam int unsigned TAG_ID_LSB   = 0;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StWaitResp,
        StResp
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: the first valid requester at or after ptr wins.
module rr_picker #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    int unsigned cand;

    // Scan farthest-to-nearest so the candidate closest to ptr overwrites the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the single Sysbus master port between requesters, one full burst at a time,
// and routes read-response beats back to the owner of the burst.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned BEATS          = SYSBUS_BEATS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_REQ-1:0]                  rq_valid,
    input  logic [N_REQ-1:0]                  rq_write,
    input  logic [N_REQ*BUS_DATA_WIDTH-1:0]   rq_addr,
    input  logic [N_REQ*BUS_TAG_WIDTH-1:0]    rq_tag,
    input  logic [N_REQ*BUS_DATA_WIDTH-1:0]   rq_wdata,
    output logic [N_REQ-1:0]                  rq_grant,
    output logic [N_REQ-1:0]                  rq_wnext,
    output logic [BEAT_W-1:0]                 rq_wbeat,
    output logic [N_REQ-1:0]                  rs_valid,
    output logic [BUS_DATA_WIDTH-1:0]         rs_data,
    output logic                              rs_last,
    output logic                              bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]         bus_req,
    output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
    input  logic                              bus_reqack,
    input  logic                              bus_respcyc,
    output logic                              bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]          bus_resptag
);

    localparam int unsigned        IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                      write_q, write_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;

    logic [N_REQ-1:0]          pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;
    logic                      beat_last;

    // Responses are routed purely by ownership; the returned tag carries no routing info.
    logic unused_resptag;
    assign unused_resptag = ^bus_resptag;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid (rq_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_onehot),
        .idx   (pick_idx)
    );

    assign pick_any  = |pick_onehot;
    assign beat_last = (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            tag_q    <= '0;
            write_q  <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            write_q  <= write_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        write_d     = write_q;
        beat_d      = beat_q;
        rq_grant    = '0;
        rq_wnext    = '0;
        rq_wbeat    = '0;
        rs_valid    = '0;
        rs_data     = '0;
        rs_last     = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        // Every response beat is acked; outside a read burst it is simply dropped.
        bus_respack = bus_respcyc;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    addr_d  = rq_addr[int'(pick_idx)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    tag_d   = rq_tag[int'(pick_idx)*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
                    write_d = rq_write[pick_idx];
                    state_d = StAddr;
                end
            end
            StAddr: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = tag_q;
                if (bus_reqack) begin
                    rq_grant[owner_q] = 1'b1;
                    rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    beat_d   = '0;
                    state_d  = write_q ? StWdata : StWaitResp;
                end
            end
            StWdata: begin
                bus_reqcyc = 1'b1;
                bus_req    = rq_wdata[int'(owner_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                bus_reqtag = tag_q;
                rq_wbeat   = beat_q;
                if (bus_reqack) begin
                    rq_wnext[owner_q] = 1'b1;
                    beat_d = beat_last ? '0 : beat_q + 1'b1;
                    if (beat_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StWaitResp, StResp: begin
                // The first beat is consumed in the same cycle it leaves WAIT_RESP.
                if (bus_respcyc) begin
                    rs_valid[owner_q] = 1'b1;
                    rs_data = bus_resp;
                    rs_last = beat_last;
                    beat_d  = beat_last ? '0 : beat_q + 1'b1;
                    state_d = beat_last ? StIdle : StResp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Scoreboard bench for sysbus_arbiter: directed bursts queue their expected bus and response
// beats, and a negedge monitor pops and compares whenever the DUT presents them.
module tb_sysbus_arbiter;
    import sysbus_pkg::*;

    localparam int unsigned W  = 64;
    localparam int unsigned TW = 13;
    localparam int unsigned N  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     rq_valid;
    logic [N-1:0]     rq_write;
    logic [N*W-1:0]   rq_addr;
    logic [N*TW-1:0]  rq_tag;
    logic [N*W-1:0]   rq_wdata;
    logic [N-1:0]     rq_grant;
    logic [N-1:0]     rq_wnext;
    logic [2:0]       rq_wbeat;
    logic [N-1:0]     rs_valid;
    logic [W-1:0]     rs_data;
    logic             rs_last;
    logic             bus_reqcyc;
    logic [W-1:0]     bus_req;
    logic [TW-1:0]    bus_reqtag;
    logic             bus_reqack;
    logic             bus_respcyc;
    logic             bus_respack;
    logic [W-1:0]     bus_resp;
    logic [TW-1:0]    bus_resptag;

    // Expected accepted bus beats: {grant, wnext, data, tag}; response beats: {valid, data, last}
    logic [80:0] bus_q[$];
    logic [66:0] resp_q[$];
    logic [80:0] head;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Requesters supply write data combinationally for the beat the arbiter presents.
    assign rq_wdata = {64'(rq_wbeat) * 64'h11, 64'hF000_0000_0000_0000 | 64'(rq_wbeat)};

    sysbus_arbiter u_dut (
        .clk         (clk),
        .reset       (reset),
        .rq_valid    (rq_valid),
        .rq_write    (rq_write),
        .rq_addr     (rq_addr),
        .rq_tag      (rq_tag),
        .rq_wdata    (rq_wdata),
        .rq_grant    (rq_grant),
        .rq_wnext    (rq_wnext),
        .rq_wbeat    (rq_wbeat),
        .rs_valid    (rs_valid),
        .rs_data     (rs_data),
        .rs_last     (rs_last),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    function automatic logic [TW-1:0] make_tag(input logic rw, input logic [3:0] ty,
                                               input logic [7:0] id);
        logic [TW-1:0] t;
        t = '0;
        t[TAG_RW_BIT] = rw;
        t[TAG_TYPE_LSB +: 4] = ty;
        t[TAG_ID_LSB +: 8] = id;
        return t;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("respack", bus_respack, bus_respcyc);
            if (bus_reqcyc) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", bus_reqcyc, 0);
                end else if (bus_reqack) begin
                    check("bus_beat", {rq_grant, rq_wnext, bus_req, bus_reqtag},
                          bus_q.pop_front());
                end else begin
                    head = bus_q[0];
                    check("bus_hold", {rq_grant, rq_wnext, bus_req, bus_reqtag},
                          {4'b0, head[76:0]});
                end
            end else begin
                check("bus_quiet", {rq_grant, rq_wnext}, 0);
            end
            if (rs_valid != 0) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", rs_valid, 0);
                end else begin
                    check("resp_beat", {rs_valid, rs_data, rs_last}, resp_q.pop_front());
                end
            end else begin
                check("resp_quiet", rs_last, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        rq_valid    = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Acts as the bus slave: waits for a request cycle, stalls `delay` cycles, then accepts.
    task automatic bus_accept(input int delay);
        int n = 0;
        logic [N-1:0] g;
        while (!bus_reqcyc && n < 100) begin
            tick();
            n++;
        end
        check("reqcyc_seen", bus_reqcyc, 1);
        repeat (delay) tick();
        bus_reqack = 1'b1;
        #1;
        g = rq_grant;
        tick();
        bus_reqack = 1'b0;
        rq_valid   = rq_valid & ~g;
    endtask

    task automatic send_resp(input logic [W-1:0] d);
        bus_respcyc = 1'b1;
        bus_resp    = d;
        tick();
        bus_respcyc = 1'b0;
        bus_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic push_addr(input logic [N-1:0] g, input logic [W-1:0] a, input logic [TW-1:0] t);
        bus_q.push_back({g, 2'b00, a, t});
    endtask

    task automatic push_resp_burst(input logic [N-1:0] v, input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            resp_q.push_back({v, base + 64'(i), (i == 7)});
        end
    endtask

    task automatic set_req(input int p, input logic wr, input logic [W-1:0] a,
                           input logic [TW-1:0] t);
        rq_write[p] = wr;
        rq_addr[p*W +: W] = a;
        rq_tag[p*TW +: TW] = t;
    endtask

    initial begin
        logic [TW-1:0] tag_a, tag_b, tag_w;
        tag_a = make_tag(SYSBUS_READ, SYSBUS_MEMORY, 8'h00);
        tag_b = make_tag(SYSBUS_READ, SYSBUS_MEMORY, 8'h01);
        tag_w = make_tag(SYSBUS_WRITE, SYSBUS_MEMORY, 8'h05);
        rq_write    = '0;
        rq_addr     = '0;
        rq_tag      = '0;
        bus_resp    = '0;
        bus_resptag = '0;
        do_reset();
        check("reset_outputs", {rq_grant, rq_wnext, rq_wbeat, rs_valid, rs_data, rs_last,
                                bus_reqcyc, bus_req, bus_reqtag, bus_respack}, 0);

        // Single read from port 0, address ack after 3 stall cycles.
        push_addr(2'b01, 64'h1000, tag_a);
        push_resp_burst(2'b01, 64'hA0, 8);
        set_req(0, 1'b0, 64'h1000, tag_a);
        rq_valid = 2'b01;
        bus_accept(3);
        for (int i = 0; i < 8; i++) send_resp(64'hA0 + 64'(i));
        tick();

        // Simultaneous reads from reset, port 0 re-requesting: grants go 0, 1, 0.
        do_reset();
        push_addr(2'b01, 64'h3000, tag_a);
        push_resp_burst(2'b01, 64'hB0, 8);
        push_addr(2'b10, 64'h4000, tag_b);
        push_resp_burst(2'b10, 64'hC0, 8);
        push_addr(2'b01, 64'h3040, tag_a);
        push_resp_burst(2'b01, 64'hD0, 8);
        set_req(0, 1'b0, 64'h3000, tag_a);
        set_req(1, 1'b0, 64'h4000, tag_b);
        rq_valid = 2'b11;
        bus_accept(0);
        for (int i = 0; i < 8; i++) send_resp(64'hB0 + 64'(i));
        set_req(0, 1'b0, 64'h3040, tag_a);
        rq_valid[0] = 1'b1;
        bus_accept(0);
        for (int i = 0; i < 8; i++) send_resp(64'hC0 + 64'(i));
        bus_accept(0);
        for (int i = 0; i < 8; i++) send_resp(64'hD0 + 64'(i));
        tick();

        // Write from port 1; beat 3 acceptance withheld for 2 cycles.
        push_addr(2'b10, 64'h2040, tag_w);
        for (int i = 0; i < 8; i++) bus_q.push_back({2'b00, 2'b10, 64'(i) * 64'h11, tag_w});
        set_req(1, 1'b1, 64'h2040, tag_w);
        rq_valid = 2'b10;
        bus_accept(0);
        for (int i = 0; i < 8; i++) bus_accept((i == 3) ? 2 : 0);
        rq_write = '0;
        tick();
        tick();

        // Read with a 2-cycle respcyc gap after the fifth beat.
        push_addr(2'b10, 64'h5000, tag_b);
        push_resp_burst(2'b10, 64'hE0, 8);
        set_req(1, 1'b0, 64'h5000, tag_b);
        rq_valid = 2'b10;
        bus_accept(1);
        for (int i = 0; i < 5; i++) send_resp(64'hE0 + 64'(i));
        tick();
        tick();
        for (int i = 5; i < 8; i++) send_resp(64'hE0 + 64'(i));
        tick();

        // Reset mid-burst: remaining beats are acked and dropped, then a fresh read completes.
        push_addr(2'b01, 64'h6000, tag_a);
        push_resp_burst(2'b01, 64'hF0, 3);
        set_req(0, 1'b0, 64'h6000, tag_a);
        rq_valid = 2'b01;
        bus_accept(0);
        for (int i = 0; i < 3; i++) send_resp(64'hF0 + 64'(i));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_reset_outputs", {rq_grant, rq_wnext, rq_wbeat, rs_valid, rs_data, rs_last,
                                     bus_reqcyc, bus_req, bus_reqtag, bus_respack}, 0);
        for (int i = 3; i < 8; i++) send_resp(64'hF0 + 64'(i));
        push_addr(2'b01, 64'h7000, tag_a);
        push_resp_burst(2'b01, 64'h90, 8);
        set_req(0, 1'b0, 64'h7000, tag_a);
        rq_valid = 2'b01;
        bus_accept(2);
        for (int i = 0; i < 8; i++) send_resp(64'h90 + 64'(i));
        tick();
        tick();

        check("bus_q_drained", bus_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between N_REQ requesters: port 0 = instruction fetch, port 1 = data memory.
- Sequences each full transaction (address beat, write-data beats or read-response beats) on behalf of one owner at a time.
- Routes response beats back to that owner.
- Sits between the core's fetch/LSU front-ends and the top-level bus pins.

Parameters:
- BUS_DATA_WIDTH, 64, bus data/address width
- BUS_TAG_WIDTH, 13, tag width: {rw[12], type[11:8], id[7:0]}
- N_REQ, 2, number of requesters
- BEATS, 8, data beats per transaction (64-byte line)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rq_valid  in  N_REQ  requester i wants a transaction; held until rq_grant[i]
- rq_write  in  N_REQ  1 = write, 0 = read
- rq_addr  in  N_REQ*64  line address per requester
- rq_tag  in  N_REQ*13  tag per requester, passed to bus unchanged
- rq_wdata  in  N_REQ*64  write data for beat rq_wbeat; combinational from requester
- rq_grant  out  N_REQ  1-cycle pulse: address beat accepted (bus_reqack)
- rq_wnext  out  N_REQ  1-cycle pulse: current write beat accepted
- rq_wbeat  out  3  index of write beat currently presented
- rs_valid  out  N_REQ  response beat for requester i this cycle; no backpressure
- rs_data  out  64  response data, shared by all requesters
- rs_last  out  1  marks final response beat
- bus_reqcyc  out  1
- bus_req  out  64
- bus_reqtag  out  13
- bus_reqack  in  1
- bus_respcyc  in  1
- bus_respack  out  1
- bus_resp  in  64
- bus_resptag  in  13

Behaviour:
- Reset
  - State goes to IDLE; rr_ptr=0; beat counter=0.
  - All outputs 0.
  - Reset mid-transaction abandons it; the requester must reissue.
- States
  - IDLE
    - Choose owner among asserted rq_valid, round-robin starting at rr_ptr.
    - Register owner, addr, tag, write; go to ADDR next cycle.
    - No request: stay in IDLE.
  - ADDR
    - bus_reqcyc=1, bus_req=addr, bus_reqtag=tag.
    - Hold until bus_reqack.
    - On ack: rq_grant[owner]=1 that cycle; rr_ptr=owner+1 mod N_REQ.
    - Next state: write → WDATA, beat=0; read → WAIT_RESP.
  - WDATA
    - bus_reqcyc=1, bus_req=rq_wdata[owner], bus_reqtag=tag; rq_wbeat=beat.
    - Each bus_reqack: rq_wnext[owner]=1, beat++.
    - After ack of beat BEATS-1 → IDLE. Writes get no response.
  - WAIT_RESP
    - bus_reqcyc=0. On bus_respcyc → RESP, processing that same cycle's beat.
  - RESP
    - Each cycle bus_respcyc=1: bus_respack=1, rs_valid[owner]=1, rs_data=bus_resp, beat++.
    - rs_last=1 on beat BEATS-1, then → IDLE.
    - bus_respcyc low mid-burst: stall with no rs_valid and no count advance.
- Stray responses
  - bus_respcyc while in IDLE/ADDR/WDATA (e.g. after reset): bus_respack=1, beat dropped, nothing forwarded.
- Other rules
  - One outstanding transaction at a time; bus_resptag is ignored for routing.
  - Owner's rq_addr/rq_tag changes after grant have no effect (registered).
  - Simultaneous requests alternate: two continuous requesters are granted 0,1,0,1…
  - Earliest re-grant: the cycle after returning to IDLE.
  - Back-to-back transactions have one IDLE bubble.
  - Beat counter is 3 bits; wraps to 0 at end of every transaction.

Decomposition:
- sysbus_pkg:
  - state enum {IDLE, ADDR, WDATA, WAIT_RESP, RESP}
  - tag field offsets
  - BEATS localparam; the existing SYSBUS_READ/WRITE/MEMORY defines reused
- Sub-module rr_picker: N_REQ-wide round-robin priority select; inputs valid vector and rr_ptr, outputs one-hot grant and index. Purely combinational.
- FSM, beat counter and datapath muxing stay in sysbus_arbiter.

Test Plan:
- Single read, port 0 addr 0x1000, tag {1,0001,00}:
  - bus_req=0x1000 held until reqack (ack after 3 cycles).
  - Then 8 beats 0xA0..0xA7 → rs_valid[0] on 8 cycles, rs_data matching, rs_last on 0xA7, respack each beat, rs_valid[1] never set.
- Simultaneous rq_valid=2'b11, both reads, from reset:
  - Port 0 granted first, port 1 second.
  - Repeating the request → port 1 first.
- Write from port 1, addr 0x2040, wdata=beat*0x11:
  - Bus sees address then 0x00,0x11..0x77.
  - rq_wnext[1] 8 pulses; reqack withheld 2 cycles on beat 3 → beat 3 held stable.
- respcyc gap: deassert respcyc after beat 4 for 2 cycles → no rs_valid during gap; remaining 3 beats forwarded; rs_last on 8th.
- Reset asserted in RESP after beat 2 → next cycle all outputs 0, IDLE; 5 remaining bus beats acked and dropped; a new port-0 read then completes normally.
